// File: rtl/multu_hilo.sv
// Sequential 32-iteration shift-add multiplier with a HI/LO result register.
// Optional signed MULT support is enabled by defining MULTU_HILO_SIGNED_MULT_EN.
module multu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    localparam int ITER = WIDTH;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    localparam logic [CW-1:0]      CNT_LAST = CW'(ITER - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_prod;
    logic [CW-1:0]        r_cnt;

    logic                 w_start_code;
    logic                 w_start;
    logic                 w_last;
    logic [WIDTH-1:0]     w_op_a;
    logic [WIDTH-1:0]     w_op_b;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_prod_next;
    logic [2*WIDTH-1:0]   w_result;

`ifdef MULTU_HILO_SIGNED_MULT_EN
    localparam logic [5:0] FN_MULT = 6'b011000;

    logic                 r_sign;
    logic                 w_is_signed;
    logic                 w_neg_a;
    logic                 w_neg_b;

    assign w_start_code = (Signal == FN_MULTU) || (Signal == FN_MULT);
    assign w_is_signed  = (Signal == FN_MULT);
    assign w_neg_a      = w_is_signed & dataA[WIDTH-1];
    assign w_neg_b      = w_is_signed & dataB[WIDTH-1];
    // The most negative value negates to itself, which read unsigned is its magnitude.
    assign w_op_a       = w_neg_a ? (~dataA + ONE_W) : dataA;
    assign w_op_b       = w_neg_b ? (~dataB + ONE_W) : dataB;
    assign w_result     = r_sign ? (~w_prod_next + ONE_2W) : w_prod_next;
`else
    assign w_start_code = (Signal == FN_MULTU);
    assign w_op_a       = dataA;
    assign w_op_b       = dataB;
    assign w_result     = w_prod_next;
`endif

    // Starts are honoured only outside the iteration phase, including the DONE cycle.
    assign w_start = (r_state != S_MUL) && w_start_code;
    assign w_last  = (r_state == S_MUL) && (r_cnt == CNT_LAST);

    // One shift-add step: conditional add into the upper half, then shift {carry, P} right.
    assign w_addend    = r_prod[0] ? r_mcand : '0;
    assign w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_prod_next = {w_sum, r_prod[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = w_start ? S_MUL : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
`ifdef MULTU_HILO_SIGNED_MULT_EN
            r_sign  <= 1'b0;
`endif
        end else if (w_start) begin
            r_mcand <= w_op_a;
            r_prod  <= {{WIDTH{1'b0}}, w_op_b};
            r_cnt   <= '0;
`ifdef MULTU_HILO_SIGNED_MULT_EN
            r_sign  <= w_neg_a ^ w_neg_b;
`endif
        end else if (r_state == S_MUL) begin
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt + CNT_ONE;
            if (w_last) begin
                r_hi <= w_result[2*WIDTH-1:WIDTH];
                r_lo <= w_result[WIDTH-1:0];
            end
        end
    end

    assign busy = (r_state == S_MUL);
    assign done = (r_state == S_DONE);

    always_comb begin
        dataOut = '0;
        if (Signal == FN_MFHI) begin
            dataOut = r_hi;
        end else if (Signal == FN_MFLO) begin
            dataOut = r_lo;
        end
    end

endmodule

// File: tb/tb_multu_hilo.sv
// Scoreboard bench for multu_hilo: stimulus queues expected HI/LO, a monitor checks each done pulse.
module tb_multu_hilo;

    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] dataOut;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    int ndone = 0;
    int nbusy = 0;
    logic [63:0] sb_q[$];

    multu_hilo #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    // Monitor: every done pulse pops one expected result and checks the busy run before it.
    always @(negedge clk) begin
        logic [63:0] e;
        logic [31:0] eo;
        if (reset) begin
            nbusy = 0;
        end else begin
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got=done want=no_done");
                end else begin
                    e  = sb_q.pop_front();
                    eo = (Signal == FN_MFLO) ? e[31:0] : (Signal == FN_MFHI) ? e[63:32] : 32'h0;
                    check("done_dataout", {32'h0, dataOut}, {32'h0, eo});
                    check("busy_len", 64'(nbusy), 64'd32);
                    check("done_not_busy", {63'h0, busy}, 64'h0);
                end
                nbusy = 0;
            end
        end
    end

    task automatic start_mul(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn,
                             input bit push, input logic [31:0] hi, input logic [31:0] lo);
        dataA  = a;
        dataB  = b;
        Signal = fn;
        if (push) sb_q.push_back({hi, lo});
        @(posedge clk);
        #1;
        t0     = cyc;
        dataA  = $urandom;
        dataB  = $urandom;
        Signal = FN_MFLO;
    endtask

    task automatic finish_mul(input string nm, input logic [31:0] hi);
        bit seen;
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({nm, "_done_seen"}, {63'h0, seen}, 64'h1);
        check({nm, "_latency"}, 64'(cyc - t0), 64'd32);
        @(posedge clk);
        #1 Signal = FN_MFHI;
        @(negedge clk);
        check({nm, "_mfhi"}, {32'h0, dataOut}, {32'h0, hi});
        #1 Signal = FN_MFLO;
    endtask

    logic [127:0] vecs [4];
    int nd0;
    bit seen6;

    initial begin
        vecs[0] = {32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        vecs[1] = {32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = {32'h0001_0001, 32'h0001_0001, 32'h0000_0001, 32'h0002_0001};
        vecs[3] = {32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};

        reset  = 1'b1;
        dataA  = '0;
        dataB  = '0;
        Signal = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        Signal = FN_MFLO;
        @(negedge clk);
        check("rst_mflo", {32'h0, dataOut}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        #1 Signal = FN_MFHI;
        @(negedge clk);
        check("rst_mfhi", {32'h0, dataOut}, 64'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            start_mul(vecs[i][127:96], vecs[i][95:64], FN_MULTU, 1, vecs[i][63:32], vecs[i][31:0]);
            finish_mul($sformatf("vec%0d", i), vecs[i][63:32]);
        end

        start_mul(32'd3, 32'd5, FN_MULTU, 1, 32'h0, 32'h0000_000F);
        finish_mul("basic", 32'h0);

        start_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, FN_MULTU, 1, 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);
        check("max_busy_mflo_prev", {32'h0, dataOut}, 64'h0000_000F);
        #1 Signal = FN_MFHI;
        @(negedge clk);
        check("max_busy_mfhi_prev", {32'h0, dataOut}, 64'h0);
        #1 Signal = FN_MFLO;
        finish_mul("max", 32'hFFFF_FFFE);

        nd0 = ndone;
        start_mul(32'h0001_0000, 32'h0001_0000, FN_MULTU, 1, 32'h1, 32'h0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        dataA  = 32'd7;
        dataB  = 32'd7;
        Signal = FN_MULTU;
        @(posedge clk);
        #1 Signal = FN_MFLO;
        finish_mul("ignored_restart", 32'h1);
        repeat (5) @(posedge clk);
        #1;
        check("one_done", 64'(ndone - nd0), 64'd1);

        start_mul(32'h1234_5678, 32'h2, FN_MULTU, 0, 32'h0, 32'h0);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        Signal = FN_MFLO;
        nd0 = ndone;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("abort_no_done", 64'(ndone - nd0), 64'd0);
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_mflo", {32'h0, dataOut}, 64'h0);
        #1 Signal = FN_MFHI;
        @(negedge clk);
        check("abort_mfhi", {32'h0, dataOut}, 64'h0);
        @(posedge clk);
        #1;
        start_mul(32'h1234_5678, 32'h2, FN_MULTU, 1, 32'h0, 32'h2468_ACF0);
        finish_mul("after_abort", 32'h0);

        dataA  = 32'd3;
        dataB  = 32'd5;
        Signal = 6'b100000;
        @(negedge clk);
        check("alu_add_out", {32'h0, dataOut}, 64'h0);
        #1 Signal = 6'b100010;
        @(posedge clk);
        @(negedge clk);
        check("alu_sub_out", {32'h0, dataOut}, 64'h0);
        check("alu_no_start", {63'h0, busy}, 64'h0);
        @(posedge clk);
        #1;

`ifdef MULTU_HILO_SIGNED_MULT_EN
        start_mul(32'hFFFF_FFFE, 32'd3, FN_MULT, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        finish_mul("mult_neg", 32'hFFFF_FFFF);

        start_mul(32'h8000_0000, 32'hFFFF_FFFF, FN_MULT, 1, 32'h0, 32'h8000_0000);
        seen6 = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen6 = 1;
                break;
            end
        end
        check("b2b_done_seen", {63'h0, seen6}, 64'h1);
        start_mul(32'd5, 32'hFFFF_FFF9, FN_MULT, 1, 32'hFFFF_FFFF, 32'hFFFF_FFDD);
        @(negedge clk);
        check("b2b_busy", {63'h0, busy}, 64'h1);
        check("b2b_prev_lo", {32'h0, dataOut}, 64'h8000_0000);
        #1 Signal = FN_MFHI;
        @(negedge clk);
        check("b2b_prev_hi", {32'h0, dataOut}, 64'h0);
        #1 Signal = FN_MFLO;
        finish_mul("b2b_mult", 32'hFFFF_FFFF);
`else
        dataA  = 32'hFFFF_FFFE;
        dataB  = 32'd3;
        Signal = FN_MULT;
        @(negedge clk);
        check("mult_code_out", {32'h0, dataOut}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        check("mult_code_no_start", {63'h0, busy}, 64'h0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
